display_timing_gen: RTL and testbench

- Generates 1280x1024@60 raster timing (108 MHz pixel clock) for the scope display path.
- Drives x, y, valid and vsync into the wave display top level.
- Drives hsync/vsync/blank, delayed to match the wave display pixel pipeline, to the video output encoder.
- Also emits a frame_start pulse for frame-synchronous logic (capture arming, UI refresh).

---
 rtl/display_timing_gen.sv | 105 ++++++++++
 tb/tb_display_timing_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// display_timing_gen: free-running raster timing with registered position/sync
// outputs and a matched delay line for the video encoder path.
`default_nettype none

module display_timing_gen #(
   parameter int   H_ACTIVE = 1280,
   parameter int   H_FP     = 48,
   parameter int   H_SYNC   = 112,
   parameter int   H_BP     = 248,
   parameter int   V_ACTIVE = 1024,
   parameter int   V_FP     = 1,
   parameter int   V_SYNC   = 3,
   parameter int   V_BP     = 38,
   parameter logic SYNC_POL = 1'b1,
   parameter int   DELAY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        valid,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start,
   output logic        hsync_d,
   output logic        vsync_d,
   output logic        blank_d
);

   localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
   localparam logic [10:0] H_SS    = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SE    = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
   localparam logic [10:0] V_SS    = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SE    = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] V_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [2:0]  PIPE_RST = {~SYNC_POL, ~SYNC_POL, 1'b1};

   logic [10:0] hcnt;
   logic [10:0] vcnt;
   logic        h_act;
   logic        v_act;

   assign h_act = (hcnt < H_ACT);
   assign v_act = (vcnt < V_ACT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? 11'd0 : vcnt + 11'd1;
      end else begin
         hcnt <= hcnt + 11'd1;
      end
   end

   // Outputs describe the position held before the edge, so they lag the
   // counters by exactly one clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x           <= '0;
         y           <= '0;
         valid       <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         frame_start <= 1'b0;
      end else begin
         x           <= h_act ? hcnt : 11'd0;
         y           <= v_act ? vcnt[9:0] : 10'd0;
         valid       <= h_act && v_act;
         hsync       <= ((hcnt >= H_SS) && (hcnt < H_SE)) ? SYNC_POL : ~SYNC_POL;
         vsync       <= ((vcnt >= V_SS) && (vcnt < V_SE)) ? SYNC_POL : ~SYNC_POL;
         frame_start <= (hcnt == 11'd0) && (vcnt == 11'd0);
      end
   end

   generate
      if (DELAY == 0) begin : g_no_delay
         assign hsync_d = hsync;
         assign vsync_d = vsync;
         assign blank_d = ~valid;
      end else begin : g_delay
         logic [2:0] pipe [DELAY];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < DELAY; i++) pipe[i] <= PIPE_RST;
            end else begin
               pipe[0] <= {hsync, vsync, ~valid};
               for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
            end
         end

         assign hsync_d = pipe[DELAY-1][2];
         assign vsync_d = pipe[DELAY-1][1];
         assign blank_d = pipe[DELAY-1][0];
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen: four instances (full geometry plus shrunken frames with
// different DELAY/SYNC_POL) checked every cycle against an arithmetic raster model.
`default_nettype none

module tb_display_timing_gen;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, d;
      bit pol;
   } geo_t;

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic        valid, hs, vs, fs, blank;
   } exp_t;

   localparam geo_t G_DEF = '{ha:1280, hf:48, hs:112, hb:248, va:1024, vf:1, vs:3, vb:38, d:2, pol:1'b1};
   localparam geo_t G_S2  = '{ha:16, hf:3, hs:4, hb:5, va:10, vf:1, vs:2, vb:3, d:2, pol:1'b1};
   localparam geo_t G_S0  = '{ha:16, hf:3, hs:4, hb:5, va:10, vf:1, vs:2, vb:3, d:0, pol:1'b0};
   localparam geo_t G_S8  = '{ha:16, hf:3, hs:4, hb:5, va:10, vf:1, vs:2, vb:3, d:8, pol:1'b1};

   logic clk = 1'b0;
   logic reset = 1'b0;
   longint k;
   int total = 0;
   int bad = 0;

   logic [10:0] a_x [4];
   logic [9:0]  a_y [4];
   logic        a_v [4], a_hs [4], a_vs [4], a_fs [4], a_hsd [4], a_vsd [4], a_bd [4];

   always #5 clk = ~clk;

   display_timing_gen u_def (
      .clk(clk), .reset(reset), .x(a_x[0]), .y(a_y[0]), .valid(a_v[0]), .hsync(a_hs[0]),
      .vsync(a_vs[0]), .frame_start(a_fs[0]), .hsync_d(a_hsd[0]), .vsync_d(a_vsd[0]), .blank_d(a_bd[0]));

   display_timing_gen #(.H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5), .V_ACTIVE(10), .V_FP(1),
                        .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1), .DELAY(2)) u_s2 (
      .clk(clk), .reset(reset), .x(a_x[1]), .y(a_y[1]), .valid(a_v[1]), .hsync(a_hs[1]),
      .vsync(a_vs[1]), .frame_start(a_fs[1]), .hsync_d(a_hsd[1]), .vsync_d(a_vsd[1]), .blank_d(a_bd[1]));

   display_timing_gen #(.H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5), .V_ACTIVE(10), .V_FP(1),
                        .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .DELAY(0)) u_s0 (
      .clk(clk), .reset(reset), .x(a_x[2]), .y(a_y[2]), .valid(a_v[2]), .hsync(a_hs[2]),
      .vsync(a_vs[2]), .frame_start(a_fs[2]), .hsync_d(a_hsd[2]), .vsync_d(a_vsd[2]), .blank_d(a_bd[2]));

   display_timing_gen #(.H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5), .V_ACTIVE(10), .V_FP(1),
                        .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1), .DELAY(8)) u_s8 (
      .clk(clk), .reset(reset), .x(a_x[3]), .y(a_y[3]), .valid(a_v[3]), .hsync(a_hs[3]),
      .vsync(a_vs[3]), .frame_start(a_fs[3]), .hsync_d(a_hsd[3]), .vsync_d(a_vsd[3]), .blank_d(a_bd[3]));

   // Count of rising edges since the last reset release.
   always @(posedge clk or negedge reset) begin
      if (!reset) k <= 0;
      else        k <= k + 1;
   end

   // Outputs after edge j show raster position j-1; j<=0 means reset values.
   function automatic exp_t model(input geo_t g, input longint j);
      exp_t e;
      longint ht, vt, p, hc, vc;
      e.x = '0; e.y = '0; e.valid = 1'b0; e.fs = 1'b0;
      e.hs = ~g.pol; e.vs = ~g.pol; e.blank = 1'b1;
      if (j > 0) begin
         ht = g.ha + g.hf + g.hs + g.hb;
         vt = g.va + g.vf + g.vs + g.vb;
         p  = (j - 1) % (ht * vt);
         hc = p % ht;
         vc = p / ht;
         e.valid = (hc < g.ha) && (vc < g.va);
         e.x     = (hc < g.ha) ? 11'(hc) : 11'd0;
         e.y     = (vc < g.va) ? 10'(vc) : 10'd0;
         e.hs    = (hc >= g.ha + g.hf && hc < g.ha + g.hf + g.hs) ? g.pol : ~g.pol;
         e.vs    = (vc >= g.va + g.vf && vc < g.va + g.vf + g.vs) ? g.pol : ~g.pol;
         e.fs    = (p == 0);
         e.blank = ~e.valid;
      end
      return e;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s k=%0d actual=%0h required=%0h", n, k, act, req);
      end
   endtask

   task automatic check_inst(input int i, input geo_t g);
      exp_t e, ed;
      string n;
      n  = $sformatf("u%0d", i);
      e  = model(g, k);
      ed = model(g, k - g.d);
      chk({n, ".x"},       32'(a_x[i]),  32'(e.x));
      chk({n, ".y"},       32'(a_y[i]),  32'(e.y));
      chk({n, ".valid"},   32'(a_v[i]),  32'(e.valid));
      chk({n, ".hsync"},   32'(a_hs[i]), 32'(e.hs));
      chk({n, ".vsync"},   32'(a_vs[i]), 32'(e.vs));
      chk({n, ".fstart"},  32'(a_fs[i]), 32'(e.fs));
      chk({n, ".hsync_d"}, 32'(a_hsd[i]), 32'(ed.hs));
      chk({n, ".vsync_d"}, 32'(a_vsd[i]), 32'(ed.vs));
      chk({n, ".blank_d"}, 32'(a_bd[i]), 32'(ed.blank));
   endtask

   task automatic check_all();
      check_inst(0, G_DEF);
      check_inst(1, G_S2);
      check_inst(2, G_S0);
      check_inst(3, G_S8);
   endtask

   bit pins_on = 1'b1;

   always @(negedge clk) begin
      check_all();
      if (pins_on && reset) begin
         case (k)
            1:    begin chk("pin_fs_first", 32'(a_fs[0]), 1); chk("pin_valid_first", 32'(a_v[0]), 1); end
            2:    chk("pin_blank_d_rst", 32'(a_bd[0]), 1);
            3:    chk("pin_blank_d_on", 32'(a_bd[0]), 0);
            1280: chk("pin_x_last", 32'(a_x[0]), 1279);
            1281: chk("pin_valid_off", 32'(a_v[0]), 0);
            1328: chk("pin_hs_before", 32'(a_hs[0]), 0);
            1329: chk("pin_hs_rise", 32'(a_hs[0]), 1);
            1440: chk("pin_hs_last", 32'(a_hs[0]), 1);
            1441: chk("pin_hs_fall", 32'(a_hs[0]), 0);
            1689: begin chk("pin_y_line1", 32'(a_y[0]), 1); chk("pin_x_line1", 32'(a_x[0]), 0); end
            308:  chk("pin_s_vs_before", 32'(a_vs[1]), 0);
            309:  begin chk("pin_s_vs_rise", 32'(a_vs[1]), 1); chk("pin_s0_vs_low", 32'(a_vs[2]), 0); end
            448:  chk("pin_s_fs_none", 32'(a_fs[1]), 0);
            449:  chk("pin_s_fs_wrap", 32'(a_fs[1]), 1);
            default: ;
         endcase
      end
   end

   initial begin
      reset = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_hs_def", 32'(a_hs[0]), 0);
      chk("rst_hs_pol0", 32'(a_hs[2]), 1);
      reset = 1'b1;
      repeat (6000) @(posedge clk);
      pins_on = 1'b0;
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(50, 3000)) @(posedge clk);
         #2;
         reset = 1'b0;
         #1;
         check_all();
         repeat ($urandom_range(1, 5)) @(posedge clk);
         @(negedge clk);
         #1;
         reset = 1'b1;
      end
      repeat (1000) @(posedge clk);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
